rs_handshake_checker: RTL and testbench
=======================================

RS_HANDSHAKE_CHECKER -- requirements
Module: rs_handshake_checker

Interface
REQ-001 Parameter SYM_W, 8, symbol width of encoderInputPort and dataOutputPort.
REQ-002 Parameter IN_LEN, 16, required encoderReadyPort high-time in cycles per packet (range 1..255).
REQ-003 Parameter OUT_LEN, 16, required encoderValidPort high-time in cycles per packet (range 1..255).
REQ-004 Parameter MAX_GAP, 0, max idle cycles (both low) allowed between phases (range 0..255).
REQ-005 Parameter CNT_W, 16, width of goodPacketCount.
REQ-006 clock  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 encoderReadyPort  input  1  encoder accepting input symbols.
REQ-009 encoderValidPort  input  1  encoder presenting output symbols.
REQ-010 encoderInputPort  input  SYM_W  input symbol bus (observed only).
REQ-011 dataOutputPort  input  SYM_W  output symbol bus.
REQ-012 errorClear  input  1  synchronous clear of errorSticky.
REQ-013 errorPulse  output  5  one-cycle flags {order, gap, out_len, in_len, mutex} (bit4..bit0).
REQ-014 errorSticky  output  5  OR-accumulated errorPulse.
REQ-015 goodPacketCount  output  CNT_W  count of error-free packets.
REQ-016 signatureOut  output  SYM_W  XOR signature of last output packet.
REQ-017 signatureValid  output  1  one-cycle pulse when signatureOut updates.

Function
REQ-018 Inputs sampled at rising clock; all outputs registered; errorPulse bit asserts the cycle after the offending sample.
REQ-019 FSM states IDLE, RX, GAP_RT (RX->TX), TX, GAP_TR (TX->RX); phase counter 8-bit, saturating at 255.
REQ-020 IDLE: ready=1 -> RX, counter=1; valid=1 -> err_order, stay IDLE; both low -> stay IDLE indefinitely, no gap error.
REQ-021 RX: ready=1 -> counter+1; counter reaching IN_LEN+1 -> err_in_len once per phase; ready=0 -> err_in_len if counter!=IN_LEN (unless already flagged), then valid=1 -> TX (counter=1) else GAP_RT (gap counter=1).
REQ-022 TX: symmetrical to RX with OUT_LEN/err_out_len; on valid=0 -> ready=1 ? RX : GAP_TR.
REQ-023 GAP_RT/GAP_TR: valid (resp. ready) =1 -> TX (resp. RX); wrong signal =1 -> err_order, enter the phase of that signal; gap counter > MAX_GAP -> err_gap, go IDLE.
REQ-024 Any cycle with ready=1 and valid=1 -> err_mutex, FSM to IDLE, packet marked bad; overrides all other transitions that cycle.
REQ-025 Packet = RX phase plus following TX phase; any error from RX entry to TX exit marks it bad.
REQ-026 TX exit of a good packet -> goodPacketCount+1, wrapping modulo 2^CNT_W.
REQ-027 errorSticky |= errorPulse each cycle; errorClear=1 -> errorSticky=0, except bits pulsing that same cycle remain set.
REQ-028 Multiple errors in one cycle -> all corresponding errorPulse bits set together.

Reset
REQ-029 reset=1 immediately forces FSM IDLE, counters 0, errorPulse 0, errorSticky 0, goodPacketCount 0, signatureOut 0, signatureValid 0.
REQ-030 Reset mid-packet abandons the packet without any error flag or count update.

Configuration
REQ-031 Macro RS_CHK_SIGNATURE_EN defined: signatureOut accumulates XOR of dataOutputPort over every TX cycle (accumulator cleared on TX entry); at TX exit signatureOut loads result and signatureValid pulses one cycle, good or bad packet.
REQ-032 Macro undefined: signatureOut constant 0, signatureValid constant 0, no accumulator logic; ports remain.

Verification
REQ-033 Defaults; ready high 16, then valid high 16 with symbols 0x01..0x10 -> errorPulse 0 throughout, goodPacketCount 1, signatureOut 0x10 with signatureValid one cycle (macro on).
REQ-034 Ready high 15 cycles then valid 16 -> errorPulse=5'b00010 once, goodPacketCount unchanged.
REQ-035 Ready and valid both high one cycle mid-RX -> errorPulse=5'b00001, FSM IDLE, errorSticky bit0 held until errorClear.
REQ-036 MAX_GAP=2; ready 16, idle 3 cycles -> errorPulse=5'b01000 on third idle sample, FSM IDLE; idle 2 then valid 16 -> no error, count+1.
REQ-037 Ready 16, idle 1, ready again (MAX_GAP=2) -> errorPulse=5'b10000, new RX phase counted from 1.
REQ-038 Assert reset at cycle 8 of TX -> all outputs 0 asynchronously; following clean packet -> goodPacketCount 1.

Source files
------------

// File: rtl/rs_handshake_checker.sv
// ============================================================================
// rs_handshake_checker : protocol monitor for an encoder ready/valid handshake.
// Optional XOR output signature is enabled by the RS_CHK_SIGNATURE_EN macro.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rs_handshake_checker #(
   parameter int SYM_W   = 8,
   parameter int IN_LEN  = 16,
   parameter int OUT_LEN = 16,
   parameter int MAX_GAP = 0,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             encoderReadyPort,
   input  logic             encoderValidPort,
   input  logic [SYM_W-1:0] encoderInputPort,
   input  logic [SYM_W-1:0] dataOutputPort,
   input  logic             errorClear,
   output logic [4:0]       errorPulse,
   output logic [4:0]       errorSticky,
   output logic [CNT_W-1:0] goodPacketCount,
   output logic [SYM_W-1:0] signatureOut,
   output logic             signatureValid
);

   localparam logic [7:0] IN_LEN_C  = 8'(IN_LEN);
   localparam logic [7:0] OUT_LEN_C = 8'(OUT_LEN);
   localparam logic [8:0] MAX_GAP_C = 9'(MAX_GAP);
   localparam bit         GAP_ZERO  = (MAX_GAP == 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RX     = 3'd1,
      S_GAP_RT = 3'd2,
      S_TX     = 3'd3,
      S_GAP_TR = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [7:0]       gap_q, gap_d;
   logic             len_flag_q, len_flag_d;
   logic             bad_q, bad_d;
   logic [4:0]       pulse_q, pulse_d;
   logic [4:0]       sticky_q, sticky_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             e_order, e_gap, e_out, e_in, e_mutex;
   logic             tx_enter, tx_exit, exit_good;
   logic [8:0]       gap_inc;
   logic             rdy, vld;

   assign rdy = encoderReadyPort;
   assign vld = encoderValidPort;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      len_flag_d = len_flag_q;
      bad_d      = bad_q;
      e_order    = 1'b0;
      e_gap      = 1'b0;
      e_out      = 1'b0;
      e_in       = 1'b0;
      e_mutex    = 1'b0;
      tx_enter   = 1'b0;
      tx_exit    = 1'b0;
      exit_good  = 1'b0;
      gap_inc    = {1'b0, gap_q} + 9'd1;

      case (state_q)
         S_IDLE: begin
            if (rdy) begin
               state_d    = S_RX;
               cnt_d      = 8'd1;
               len_flag_d = 1'b0;
               bad_d      = 1'b0;
            end else if (vld) begin
               e_order = 1'b1;
            end
         end
         S_RX: begin
            if (rdy) begin
               cnt_d = sat_inc(cnt_q);
               if (cnt_q == IN_LEN_C && !len_flag_q) begin
                  e_in       = 1'b1;
                  len_flag_d = 1'b1;
               end
            end else begin
               if (cnt_q != IN_LEN_C && !len_flag_q) e_in = 1'b1;
               len_flag_d = 1'b0;
               if (vld) begin
                  state_d  = S_TX;
                  cnt_d    = 8'd1;
                  tx_enter = 1'b1;
               end else if (GAP_ZERO) begin
                  e_gap   = 1'b1;
                  state_d = S_IDLE;
                  cnt_d   = 8'd0;
               end else begin
                  state_d = S_GAP_RT;
                  gap_d   = 8'd1;
                  cnt_d   = 8'd0;
               end
            end
         end
         S_GAP_RT: begin
            if (vld) begin
               state_d  = S_TX;
               cnt_d    = 8'd1;
               gap_d    = 8'd0;
               tx_enter = 1'b1;
            end else if (rdy) begin
               // Early ready abandons the current packet and opens a new, already-bad one
               e_order    = 1'b1;
               state_d    = S_RX;
               cnt_d      = 8'd1;
               gap_d      = 8'd0;
               len_flag_d = 1'b0;
               bad_d      = 1'b1;
            end else if (gap_inc > MAX_GAP_C) begin
               e_gap   = 1'b1;
               state_d = S_IDLE;
               gap_d   = 8'd0;
            end else begin
               gap_d = gap_inc[7:0];
            end
         end
         S_TX: begin
            if (vld) begin
               cnt_d = sat_inc(cnt_q);
               if (cnt_q == OUT_LEN_C && !len_flag_q) begin
                  e_out      = 1'b1;
                  len_flag_d = 1'b1;
               end
            end else begin
               if (cnt_q != OUT_LEN_C && !len_flag_q) e_out = 1'b1;
               tx_exit    = 1'b1;
               exit_good  = !bad_q && !e_out;
               len_flag_d = 1'b0;
               if (rdy) begin
                  state_d = S_RX;
                  cnt_d   = 8'd1;
                  bad_d   = 1'b0;
               end else if (GAP_ZERO) begin
                  e_gap   = 1'b1;
                  state_d = S_IDLE;
                  cnt_d   = 8'd0;
               end else begin
                  state_d = S_GAP_TR;
                  gap_d   = 8'd1;
                  cnt_d   = 8'd0;
               end
            end
         end
         S_GAP_TR: begin
            if (rdy) begin
               state_d    = S_RX;
               cnt_d      = 8'd1;
               gap_d      = 8'd0;
               len_flag_d = 1'b0;
               bad_d      = 1'b0;
            end else if (vld) begin
               e_order    = 1'b1;
               state_d    = S_TX;
               cnt_d      = 8'd1;
               gap_d      = 8'd0;
               len_flag_d = 1'b0;
               bad_d      = 1'b1;
               tx_enter   = 1'b1;
            end else if (gap_inc > MAX_GAP_C) begin
               e_gap   = 1'b1;
               state_d = S_IDLE;
               gap_d   = 8'd0;
            end else begin
               gap_d = gap_inc[7:0];
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Errors seen while a packet is in flight taint it; a TX exit error is handled by exit_good
      if ((state_q == S_RX || state_q == S_GAP_RT || (state_q == S_TX && vld)) &&
          (e_order || e_gap || e_out || e_in))
         bad_d = 1'b1;

      if (rdy && vld) begin
         e_mutex    = 1'b1;
         state_d    = S_IDLE;
         cnt_d      = 8'd0;
         gap_d      = 8'd0;
         len_flag_d = 1'b0;
         bad_d      = 1'b1;
         tx_enter   = 1'b0;
         tx_exit    = 1'b0;
         exit_good  = 1'b0;
      end

      pulse_d  = {e_order, e_gap, e_out, e_in, e_mutex};
      sticky_d = errorClear ? pulse_d : (sticky_q | pulse_d);
      count_d  = exit_good ? count_q + CNT_W'(1) : count_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'd0;
         gap_q      <= 8'd0;
         len_flag_q <= 1'b0;
         bad_q      <= 1'b0;
         pulse_q    <= 5'd0;
         sticky_q   <= 5'd0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gap_q      <= gap_d;
         len_flag_q <= len_flag_d;
         bad_q      <= bad_d;
         pulse_q    <= pulse_d;
         sticky_q   <= sticky_d;
         count_q    <= count_d;
      end
   end

   assign errorPulse      = pulse_q;
   assign errorSticky     = sticky_q;
   assign goodPacketCount = count_q;

`ifdef RS_CHK_SIGNATURE_EN
   logic [SYM_W-1:0] acc_q, acc_d;
   logic [SYM_W-1:0] sig_q, sig_d;
   logic             sig_valid_q, sig_valid_d;

   always_comb begin
      acc_d       = acc_q;
      sig_d       = sig_q;
      sig_valid_d = 1'b0;
      if (tx_enter)
         acc_d = dataOutputPort;
      else if (state_q == S_TX && vld)
         acc_d = acc_q ^ dataOutputPort;
      if (tx_exit) begin
         sig_d       = acc_q;
         sig_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q       <= '0;
         sig_q       <= '0;
         sig_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         sig_q       <= sig_d;
         sig_valid_q <= sig_valid_d;
      end
   end

   assign signatureOut   = sig_q;
   assign signatureValid = sig_valid_q;
`else
   assign signatureOut   = '0;
   assign signatureValid = 1'b0;
`endif

   // Input symbols are observed only; fold them into a deliberately unused net
   logic unused_ok;
   assign unused_ok = ^{encoderInputPort, dataOutputPort, tx_enter, tx_exit};

endmodule

`default_nettype wire

// File: tb/tb_rs_handshake_checker.sv
// ============================================================================
// tb_rs_handshake_checker : directed scoreboard bench for rs_handshake_checker.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rs_handshake_checker;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rdy = 1'b0, vld = 1'b0, clr = 1'b0;
   logic [7:0]  din = 8'd0, dout = 8'd0;
   logic [4:0]  errorPulse, errorSticky;
   logic [15:0] goodPacketCount;
   logic [7:0]  signatureOut;
   logic        signatureValid;

   rs_handshake_checker #(
      .SYM_W(8), .IN_LEN(16), .OUT_LEN(16), .MAX_GAP(2), .CNT_W(16)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .encoderReadyPort(rdy),
      .encoderValidPort(vld),
      .encoderInputPort(din),
      .dataOutputPort  (dout),
      .errorClear      (clr),
      .errorPulse      (errorPulse),
      .errorSticky     (errorSticky),
      .goodPacketCount (goodPacketCount),
      .signatureOut    (signatureOut),
      .signatureValid  (signatureValid)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  ep;
      logic [15:0] cnt;
      logic [7:0]  sig;
      logic        sv;
   } exp_t;

   exp_t        q[$];
   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] exp_cnt = 16'd0;
   logic [7:0]  exp_sig = 8'd0;
   logic [7:0]  acc = 8'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ex: 0 = no TX exit on this sample, 1 = good packet exit, 2 = bad packet exit
   task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic c,
                      input logic [4:0] ep, input int ex);
      exp_t e;
      @(negedge clock);
      rdy = r; vld = v; dout = d; din = d ^ 8'h5A; clr = c;
      if (v) acc = acc ^ d;
      e.sv = 1'b0;
      if (ex != 0) begin
`ifdef RS_CHK_SIGNATURE_EN
         exp_sig = acc;
         e.sv    = 1'b1;
`endif
         if (ex == 1) exp_cnt = exp_cnt + 16'd1;
      end
      e.ep  = ep;
      e.cnt = exp_cnt;
      e.sig = exp_sig;
      q.push_back(e);
   endtask

   task automatic rx(input int n, input int err_at);
      for (int i = 1; i <= n; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, (i == err_at) ? 5'b00010 : 5'b00000, 0);
   endtask

   task automatic tx(input int n, input logic [7:0] base, input logic [4:0] first_ep);
      acc = 8'd0;
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, base + 8'(i), 1'b0, (i == 0) ? first_ep : 5'b00000, 0);
   endtask

   task automatic idle(input int n, input int gap_at);
      for (int i = 1; i <= n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, (i == gap_at) ? 5'b01000 : 5'b00000, 0);
   endtask

   task automatic chk_sticky(input logic [4:0] exp);
      @(posedge clock);
      #2;
      check("errorSticky", errorSticky, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      check({tag, " errorPulse"}, errorPulse, 0);
      check({tag, " errorSticky"}, errorSticky, 0);
      check({tag, " goodPacketCount"}, goodPacketCount, 0);
      check({tag, " signatureOut"}, signatureOut, 0);
      check({tag, " signatureValid"}, signatureValid, 0);
   endtask

   // Monitor: one expected record per driven sample, compared just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (!reset && q.size() != 0) begin
            e = q.pop_front();
            check("errorPulse", errorPulse, e.ep);
            check("goodPacketCount", goodPacketCount, e.cnt);
            check("signatureOut", signatureOut, e.sig);
            check("signatureValid", signatureValid, e.sv);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clock);
      chk_all_zero("reset");
      reset = 1'b0;

      // Clean packet, symbols 0x01..0x10
      rx(16, 0);
      tx(16, 8'h01, 5'b00000);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'b00000, 1);
      idle(2, 2);
      chk_sticky(5'b01000);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 5'b00000, 0);
      chk_sticky(5'b00000);

      // RX too long: flagged once at the 17th ready sample only
      rx(18, 17);
      tx(16, 8'h11, 5'b00000);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'b00000, 2);
      idle(2, 2);

      // RX too short (15)
      rx(15, 0);
      tx(16, 8'hA0, 5'b00010);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'b00000, 2);
      idle(2, 2);
      chk_sticky(5'b01010);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 5'b00000, 0);

      // TX too short (15): flagged on the exit sample
      rx(16, 0);
      tx(15, 8'h40, 5'b00000);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'b00100, 2);
      idle(2, 2);

      // Gap of exactly MAX_GAP between phases is legal
      rx(16, 0);
      idle(2, 0);
      tx(16, 8'h30, 5'b00000);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'b00000, 1);
      idle(2, 2);

      // Gap of MAX_GAP+1 is an error, then IDLE tolerates idling
      rx(16, 0);
      idle(3, 3);
      idle(3, 0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 5'b00000, 0);

      // Mutex mid-RX, sticky held until cleared
      rx(5, 0);
      cyc(1'b1, 1'b1, 8'h00, 1'b0, 5'b00001, 0);
      idle(3, 0);
      chk_sticky(5'b00001);
      // Clear coinciding with a new error keeps that error's bit
      cyc(1'b0, 1'b1, 8'h77, 1'b1, 5'b10000, 0);
      chk_sticky(5'b10000);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 5'b00000, 0);
      chk_sticky(5'b00000);

      // Ready returns during RX->TX gap: order error, new RX counted from 1
      rx(16, 0);
      idle(1, 0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 5'b10000, 0);
      rx(15, 0);
      tx(8, 8'h60, 5'b00000);

      // Asynchronous reset during TX cycle 8
      @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      chk_all_zero("async reset");
      exp_cnt = 16'd0;
      exp_sig = 8'd0;
      @(negedge clock);
      rdy = 1'b0; vld = 1'b0; clr = 1'b0;
      @(negedge clock);
      reset = 1'b0;

      // Clean packet after reset
      rx(16, 0);
      tx(16, 8'h51, 5'b00000);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 5'b00000, 1);
      idle(2, 2);

      repeat (3) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
